// File: rtl/uart_pkg.sv
// rtl/uart_pkg.sv - shared types and constants for the UART receive deframer
//
// Purpose: receiver state encoding, frame geometry, default baud NCO settings
// and the parity rule used by the deframer.
// Ports: none (package).
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } rx_state_e;

  localparam int FRAME_DBITS   = 8;

  // 7550 / 2^16 of a bit per 10 ns cycle gives 11.52 Mbaud at 100 MHz.
  localparam int DEF_ACC_W     = 16;
  localparam int DEF_BAUD_INC  = 7550;

  // Parity mode: even parity, the parity bit equals the XOR of the data bits.
  localparam logic PARITY_EVEN = 1'b0;

  function automatic logic calc_parity(input logic [FRAME_DBITS-1:0] data);
    return (^data) ^ PARITY_EVEN;
  endfunction

endpackage

// File: rtl/uart_baud_nco.sv
// rtl/uart_baud_nco.sv - fractional baud-rate NCO producing mid-bit sample ticks
//
// Purpose: phase accumulator whose carry out marks each bit sample point.
// Ports:
//   clk_sys - system clock
//   rst_n   - asynchronous active-low reset
//   run     - advance the accumulator this cycle
//   load    - preload HALF_PHASE (start edge seen); has priority over run
//   tick    - carry out of the accumulator addition, qualified by run
module uart_baud_nco #(
  parameter int ACC_W      = 16,
  parameter int BAUD_INC   = 7550,
  parameter int HALF_PHASE = 2 ** (ACC_W - 1)
) (
  input  logic clk_sys,
  input  logic rst_n,
  input  logic run,
  input  logic load,
  output logic tick
);

  localparam logic [ACC_W:0]   INC  = (ACC_W + 1)'(BAUD_INC);
  localparam logic [ACC_W-1:0] HALF = ACC_W'(HALF_PHASE);

  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W:0]   sum;

  always_comb begin
    sum   = {1'b0, acc_q} + INC;
    tick  = run & sum[ACC_W];
    acc_d = acc_q;
    if (load) begin
      acc_d = HALF;
    end else if (run) begin
      acc_d = sum[ACC_W-1:0];
    end
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/uart_rx_frame.sv
// rtl/uart_rx_frame.sv - UART receive deframer: start, 8 data MSB first, even parity, stop
//
// Purpose: recovers bytes from the asynchronous serial line and strobes them
// with parity/framing error flags to the command assembler.
// Ports:
//   clk_sys - system clock, 100 MHz nominal
//   rst_n   - asynchronous active-low reset
//   uart_rx - asynchronous serial line, idle high
//   rx_data - last received byte, bit7 = first data bit on the line
//   rx_vld  - one-cycle strobe qualifying rx_data/rx_perr/rx_ferr
//   rx_perr - parity mismatch for the strobed byte
//   rx_ferr - stop bit sampled low for the strobed byte
//   rx_busy - high while a frame is in progress
module uart_rx_frame
  import uart_pkg::*;
#(
  parameter int ACC_W      = DEF_ACC_W,
  parameter int BAUD_INC   = DEF_BAUD_INC,
  parameter int HALF_PHASE = 2 ** (ACC_W - 1)
) (
  input  logic                   clk_sys,
  input  logic                   rst_n,
  input  logic                   uart_rx,
  output logic [FRAME_DBITS-1:0] rx_data,
  output logic                   rx_vld,
  output logic                   rx_perr,
  output logic                   rx_ferr,
  output logic                   rx_busy
);

  // Synchronizer and previous-sample flops reset high so a line held low at
  // reset release never looks like a falling edge.
  logic sync1_q, sync2_q, prev_q;
  logic line, fall;

  rx_state_e state_q, state_d;
  logic [2:0]             bit_cnt_q, bit_cnt_d;
  logic [FRAME_DBITS-1:0] shift_q, shift_d;
  logic                   par_q, par_d;
  logic                   armed_q, armed_d;
  logic [FRAME_DBITS-1:0] data_q, data_d;
  logic                   vld_q, vld_d;
  logic                   perr_q, perr_d;
  logic                   ferr_q, ferr_d;
  logic                   nco_load, nco_run, tick;

  assign line = sync2_q;
  assign fall = prev_q & ~sync2_q;

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
      prev_q  <= 1'b1;
    end else begin
      sync1_q <= uart_rx;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  uart_baud_nco #(
    .ACC_W      (ACC_W),
    .BAUD_INC   (BAUD_INC),
    .HALF_PHASE (HALF_PHASE)
  ) u_nco (
    .clk_sys (clk_sys),
    .rst_n   (rst_n),
    .run     (nco_run),
    .load    (nco_load),
    .tick    (tick)
  );

  assign nco_run = (state_q != IDLE);

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    par_d     = par_q;
    armed_d   = armed_q;
    data_d    = data_q;
    vld_d     = 1'b0;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    nco_load  = 1'b0;

    // Re-arm whenever the line is seen idle; the STOP branch below can only
    // disarm when the line is low, so the two never collide.
    if (line) begin
      armed_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (fall && armed_q) begin
          state_d  = START;
          nco_load = 1'b1;
        end
      end
      START: begin
        // A low pulse shorter than half a bit reads high here and is dropped.
        if (tick) begin
          if (!line) begin
            state_d   = DATA;
            bit_cnt_d = 3'(FRAME_DBITS - 1);
          end else begin
            state_d = IDLE;
          end
        end
      end
      DATA: begin
        if (tick) begin
          shift_d[bit_cnt_q] = line;
          bit_cnt_d          = bit_cnt_q - 3'd1;
          if (bit_cnt_q == 3'd0) begin
            state_d = PARITY;
          end
        end
      end
      PARITY: begin
        if (tick) begin
          par_d   = line;
          state_d = STOP;
        end
      end
      STOP: begin
        // Leave at mid-stop so a start edge right after the stop bit is caught.
        if (tick) begin
          state_d = IDLE;
          vld_d   = 1'b1;
          data_d  = shift_q;
          perr_d  = par_q ^ calc_parity(shift_q);
          ferr_d  = ~line;
          if (!line) begin
            armed_d = 1'b0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      par_q     <= 1'b0;
      armed_q   <= 1'b0;
      data_q    <= '0;
      vld_q     <= 1'b0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      par_q     <= par_d;
      armed_q   <= armed_d;
      data_q    <= data_d;
      vld_q     <= vld_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
    end
  end

  assign rx_data = data_q;
  assign rx_vld  = vld_q;
  assign rx_perr = perr_q;
  assign rx_ferr = ferr_q;
  assign rx_busy = (state_q != IDLE);

endmodule
